div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle RV32M integer divider (DIV, DIVU, REM, REMU) in the Execute stage.
- It is the stall-request side of the pipeline hazard interface. It raises BusyE while a division is in flight; the hazard unit uses BusyE to stall F/D/E.
- It obeys FlushE from the hazard unit to abort an in-flight operation.
- Radix-2 restoring division, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StartE  in  1  divide instruction present in Execute
- FunctE  in  2  div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- SrcAE  in  XLEN  dividend (post-forwarding)
- SrcBE  in  XLEN  divisor (post-forwarding)
- FlushE  in  1  kill the Execute-stage instruction
- BusyE  out  1  stall request to hazard unit
- DoneE  out  1  ResultE valid this cycle
- ResultE  out  XLEN  quotient or remainder

Behaviour:
- States: IDLE, CALC, DONE. Iteration counter width is $clog2(XLEN)+1.
- Reset: state=IDLE, counter=0, quotient/remainder/result registers=0, DoneE=0, BusyE=0.
- Priority, highest first: reset, then FlushE, then normal operation.
- BusyE = (IDLE & StartE & ~FlushE) | CALC. It is combinational; it is 0 in DONE so the instruction leaves E at the end of the DONE cycle.
- IDLE, StartE=1:
  - Latch the op.
  - Latch the operand magnitudes: signed ops take the absolute value. Latch the quotient sign (signA^signB) and the remainder sign (signA).
  - Special cases go directly to DONE with the result preloaded:
    - divisor==0: quotient = all ones; remainder = SrcAE.
    - signed op, SrcAE=0x8000_0000, SrcBE=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
  - Otherwise go to CALC with counter=XLEN.
- CALC:
  - Each cycle, shift the partial remainder left by one and bring in the next dividend MSB.
  - If partial remainder ≥ divisor, subtract it and set quotient bit = 1; otherwise quotient bit = 0.
  - Decrement the counter; at counter==1 → DONE.
- DONE:
  - DoneE=1. ResultE = sign-corrected quotient (DIV/DIVU) or sign-corrected remainder (REM/REMU). Negate when the latched sign is 1 and the op is signed.
  - Next state is IDLE unconditionally, even if StartE is still high, so the same instruction is not restarted.
- Latency, StartE to DoneE: XLEN+1 cycles for normal ops (33 at XLEN=32); 1 cycle for special cases.
- ResultE holds its last value outside DONE and is ignored by consumers when DoneE=0.
- FlushE:
  - In IDLE, blocks the start.
  - In CALC or DONE, forces IDLE next cycle with DoneE=0 and no result update.
  - BusyE drops the cycle after FlushE is sampled in CALC.
- StartE dropping mid-CALC (without FlushE) is illegal; an SVA assertion flags it.
- reset asserted mid-CALC: all state returns to reset values on the next edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With the macro: in IDLE, if the unsigned magnitudes satisfy |A| < |B| (and no special case applies), go directly to DONE with quotient=0 and remainder=SrcAE. Latency is 1 cycle.
- Without the macro: these operands take the full XLEN-cycle CALC path. Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_op_t {DIV, DIVU, REM, REMU}.
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, DONE}.
  - Constant DIV_BY_ZERO_Q = all ones.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: next partial remainder, quotient bit.

Test Plan:
- DIVU 100/7 → BusyE high for 33 cycles, DoneE pulse once, ResultE=14; REMU same operands → 2.
- DIV -7/2 → ResultE=0xFFFF_FFFD (-3); REM -7/2 → 0xFFFF_FFFF (-1); remainder sign follows dividend.
- DIV 5/0 → DoneE on the cycle after StartE, ResultE=0xFFFF_FFFF; REM 5/0 → 5.
- DIV 0x8000_0000 / 0xFFFF_FFFF → ResultE=0x8000_0000 after 1 cycle; REM → 0.
- FlushE pulsed at CALC cycle 10 → BusyE low the next cycle, no DoneE. A new DIVU 9/3 started afterwards → 3, with no residue from the aborted op.
- DIVU 3/10:
  - with DIV_EARLY_OUT_EN → DoneE after 1 cycle, ResultE=0;
  - without it → DoneE after 33 cycles, ResultE=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M multi-cycle divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam int DIV_MAX_XLEN = 64;
  localparam logic [DIV_MAX_XLEN-1:0] DIV_BY_ZERO_Q = '1;

  function automatic logic isSignedOp(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic isRemOp(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] remIn,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividendBit,
  output logic [XLEN-1:0] remOut,
  output logic            qBit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // remIn < divisor always holds, so the shifted value fits in XLEN+1 bits
  // and the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted = {remIn, dividendBit};
    diff    = shifted - {1'b0, divisor};
    qBit    = ~diff[XLEN];
    remOut  = qBit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with hazard-unit stall/flush handshake.
// Optional macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  div_op_t         FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [CW-1:0]   count;
  logic            opRem;
  logic            negQ;
  logic            negR;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;

  logic            signedIn;
  logic            signA;
  logic            signB;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic            specialHit;
  logic [XLEN-1:0] specQ;
  logic [XLEN-1:0] specR;
  logic [XLEN-1:0] remStep;
  logic            qBitStep;
  logic [XLEN-1:0] quotNext;

  function automatic logic [XLEN-1:0] signFix(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (XLEN)'(-v) : v;
  endfunction

  div_step #(.XLEN(XLEN)) uStep (
    .remIn      (rem),
    .divisor    (divisor),
    .dividendBit(quot[XLEN-1]),
    .remOut     (remStep),
    .qBit       (qBitStep)
  );

  assign quotNext = {quot[XLEN-2:0], qBitStep};
  assign BusyE    = ((state == IDLE) && StartE && !FlushE) || (state == CALC);

  // Operand conditioning and the one-cycle shortcut cases; shortcut results carry no sign fix-up.
  always_comb begin
    signedIn   = isSignedOp(FunctE);
    signA      = signedIn & SrcAE[XLEN-1];
    signB      = signedIn & SrcBE[XLEN-1];
    magA       = signA ? (XLEN)'(-SrcAE) : SrcAE;
    magB       = signB ? (XLEN)'(-SrcBE) : SrcBE;
    specialHit = 1'b0;
    specQ      = '0;
    specR      = '0;
    if (SrcBE == '0) begin
      specialHit = 1'b1;
      specQ      = DIV_BY_ZERO_Q[XLEN-1:0];
      specR      = SrcAE;
    end else if (signedIn && (SrcAE == MIN_NEG) && (SrcBE == '1)) begin
      specialHit = 1'b1;
      specQ      = MIN_NEG;
      specR      = '0;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (magA < magB) begin
      specialHit = 1'b1;
      specQ      = '0;
      specR      = SrcAE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      opRem   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      ResultE <= '0;
      DoneE   <= 1'b0;
    end else if (FlushE) begin
      state <= IDLE;
      count <= '0;
      DoneE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DoneE <= 1'b0;
          if (StartE) begin
            opRem   <= isRemOp(FunctE);
            divisor <= magB;
            if (specialHit) begin
              quot    <= specQ;
              rem     <= specR;
              negQ    <= 1'b0;
              negR    <= 1'b0;
              ResultE <= isRemOp(FunctE) ? specR : specQ;
              DoneE   <= 1'b1;
              state   <= DONE;
            end else begin
              quot  <= magA;
              rem   <= '0;
              negQ  <= signA ^ signB;
              negR  <= signA;
              count <= CW'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          quot  <= quotNext;
          rem   <= remStep;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            ResultE <= opRem ? signFix(remStep, negR) : signFix(quotNext, negQ);
            DoneE   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          DoneE <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The hazard unit keeps the instruction in E while we are busy.
  assert property (@(posedge clk) disable iff (reset)
    ((state == CALC) && !FlushE) |-> StartE);

endmodule

// File: tb/tb_div_unit.sv
// Directed table-driven bench for div_unit plus flush/reset corner sequences.
module tb_div_unit;
  import div_pkg::*;

  localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LE = 1;
`else
  localparam int LE = 33;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            StartE;
  div_op_t         FunctE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            BusyE;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .StartE (StartE),
    .FunctE (FunctE),
    .SrcAE  (SrcAE),
    .SrcBE  (SrcBE),
    .FlushE (FlushE),
    .BusyE  (BusyE),
    .DoneE  (DoneE),
    .ResultE(ResultE)
  );

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic runOp(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy,
                       output logic busyInDone);
    @(negedge clk);
    FunctE = op;
    SrcAE  = a;
    SrcBE  = b;
    StartE = 1'b1;
    res = '0; lat = -1; busy = 0; busyInDone = 1'bx;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (DoneE) begin
        lat = k;
        res = ResultE;
        busyInDone = BusyE;
        break;
      end
      if (BusyE) busy++;
      @(negedge clk);
    end
    StartE = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;
  int          busy;
  logic        busyInDone;
  int          doneCount;
  string       tag;

  initial begin
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{DIVU, 32'd3,          32'd10,         32'd0,          LE};
    vecs[9]  = '{REMU, 32'd3,          32'd10,         32'd3,          LE};
    vecs[10] = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[11] = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[12] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};
    vecs[13] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};
    vecs[14] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[15] = '{DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33};
    vecs[16] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LE};
    vecs[17] = '{REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};

    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; FunctE = DIVU; SrcAE = '0; SrcBE = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset BusyE", 32'(BusyE), 32'd0);
    check("reset DoneE", 32'(DoneE), 32'd0);
    check("reset ResultE", ResultE, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy, busyInDone);
      tag = $sformatf("vec%0d", i);
      check({tag, " result"}, res, vecs[i].res);
      check({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
      check({tag, " busy cycles"}, 32'(busy), 32'(vecs[i].lat));
      check({tag, " BusyE in DONE"}, 32'(busyInDone), 32'd0);
      @(negedge clk); #1;
      check({tag, " DoneE single pulse"}, 32'(DoneE), 32'd0);
    end

    // FlushE in IDLE suppresses the start.
    @(negedge clk);
    FunctE = DIVU; SrcAE = 32'd50; SrcBE = 32'd5; StartE = 1'b1; FlushE = 1'b1;
    #1;
    check("idle flush BusyE", 32'(BusyE), 32'd0);
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    #1;
    check("idle flush stays idle BusyE", 32'(BusyE), 32'd0);
    check("idle flush DoneE", 32'(DoneE), 32'd0);

    // FlushE at CALC cycle 10 aborts the division.
    @(negedge clk);
    FunctE = DIVU; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    #1;
    check("calc flush BusyE during flush", 32'(BusyE), 32'd1);
    @(negedge clk);
    FlushE = 1'b0; StartE = 1'b0;
    #1;
    check("calc flush BusyE after", 32'(BusyE), 32'd0);
    check("calc flush DoneE after", 32'(DoneE), 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (DoneE) doneCount++;
    end
    check("calc flush no DoneE", 32'(doneCount), 32'd0);
    runOp(DIVU, 32'd9, 32'd3, res, lat, busy, busyInDone);
    check("post flush DIVU 9/3", res, 32'd3);
    check("post flush latency", 32'(lat), 32'd33);

    // Reset in the middle of CALC.
    @(negedge clk);
    FunctE = DIVU; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; StartE = 1'b0;
    #1;
    check("mid reset BusyE", 32'(BusyE), 32'd0);
    check("mid reset DoneE", 32'(DoneE), 32'd0);
    check("mid reset ResultE", ResultE, 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (DoneE) doneCount++;
    end
    check("mid reset no DoneE", 32'(doneCount), 32'd0);
    runOp(REMU, 32'd1000, 32'd3, res, lat, busy, busyInDone);
    check("post reset REMU 1000/3", res, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
